// File: rtl/xgmii_rx_deframer.sv
// XGMII receive deframer: strips start/preamble/SFD/terminate/idle symbols from
// 32-bit lane words and emits payload beats with keep/last/err toward the RX MAC.

module xgmii_rx_lane (
  input  logic [7:0] d,
  input  logic       c,
  output logic       term
);
  assign term = c & (d == 8'hFD);
endmodule

module xgmii_rx_deframer #(
  parameter int W_DATA = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W_DATA-1:0]   i_xgmii_d,
  input  logic [W_DATA/8-1:0] i_xgmii_c,
  input  logic                i_xgmii_vld,
  output logic [W_DATA-1:0]   o_data,
  output logic [W_DATA/8-1:0] o_keep,
  output logic                o_valid,
  output logic                o_last,
  output logic                o_err
);
  localparam int NUM_LANES = W_DATA / 8;
  localparam logic [W_DATA-1:0]    START_W = W_DATA'(32'h555555FB);
  localparam logic [W_DATA-1:0]    SFD_W   = W_DATA'(32'hD5555555);
  localparam logic [NUM_LANES-1:0] C_LANE0 = NUM_LANES'(1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_FLUSH, S_DROP} state_t;

  state_t                state, state_nx;
  logic [W_DATA-1:0]     buf_d, buf_d_nx;
  logic [NUM_LANES-1:0]  buf_k, buf_k_nx;
  logic                  buf_vld, buf_vld_nx;
  logic [W_DATA-1:0]     data_nx;
  logic [NUM_LANES-1:0]  keep_nx;
  logic                  valid_nx, last_nx, err_nx;

  logic [NUM_LANES-1:0]  term;
  logic [NUM_LANES-1:0]  keep_lo;
  logic [W_DATA-1:0]     data_lo;
  logic                  ctl_any, ctl_term;
  logic                  start_w, sfd_w, start_sym, drop_exit;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    xgmii_rx_lane u_lane (
      .d    (i_xgmii_d[8*g +: 8]),
      .c    (i_xgmii_c[g]),
      .term (term[g])
    );
  end

  // Lanes ahead of the first control lane are payload; that control lane
  // decides between a clean terminate and a corrupt frame.
  always_comb begin
    ctl_any  = 1'b0;
    ctl_term = 1'b0;
    keep_lo  = '0;
    data_lo  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (!ctl_any && i_xgmii_c[k]) begin
        ctl_any  = 1'b1;
        ctl_term = term[k];
      end
      if (!ctl_any) begin
        keep_lo[k]      = 1'b1;
        data_lo[8*k +: 8] = i_xgmii_d[8*k +: 8];
      end
    end
  end

  assign start_w   = (i_xgmii_c == C_LANE0) && (i_xgmii_d == START_W);
  assign sfd_w     = (i_xgmii_c == '0) && (i_xgmii_d == SFD_W);
  assign start_sym = (i_xgmii_c == C_LANE0) && (i_xgmii_d[7:0] == 8'hFB);
  assign drop_exit = (|term) || ((&i_xgmii_c) && (i_xgmii_d[7:0] == 8'h07));

  always_comb begin
    state_nx   = state;
    buf_d_nx   = buf_d;
    buf_k_nx   = buf_k;
    buf_vld_nx = buf_vld;
    valid_nx   = 1'b0;
    last_nx    = 1'b0;
    err_nx     = 1'b0;
    data_nx    = '0;
    keep_nx    = '0;
    case (state)
      S_IDLE: begin
        if (i_xgmii_vld && start_w) state_nx = S_PRE;
      end
      S_PRE: begin
        if (i_xgmii_vld) begin
          if (sfd_w) begin
            state_nx   = S_DATA;
            buf_vld_nx = 1'b0;
          end else if (!start_w) begin
            state_nx = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (i_xgmii_vld) begin
          if (!ctl_any) begin
            valid_nx   = buf_vld;
            data_nx    = buf_vld ? buf_d : '0;
            keep_nx    = buf_vld ? buf_k : '0;
            buf_d_nx   = i_xgmii_d;
            buf_k_nx   = '1;
            buf_vld_nx = 1'b1;
          end else if (ctl_term) begin
            valid_nx = buf_vld;
            data_nx  = buf_vld ? buf_d : '0;
            keep_nx  = buf_vld ? buf_k : '0;
            if (keep_lo == '0) begin
              // Terminate in lane 0 closes the held word directly.
              last_nx    = buf_vld;
              buf_vld_nx = 1'b0;
              state_nx   = S_IDLE;
            end else begin
              buf_d_nx   = data_lo;
              buf_k_nx   = keep_lo;
              buf_vld_nx = 1'b1;
              state_nx   = S_FLUSH;
            end
          end else begin
            valid_nx   = 1'b1;
            last_nx    = 1'b1;
            err_nx     = 1'b1;
            data_nx    = buf_vld ? buf_d : '0;
            keep_nx    = buf_vld ? buf_k : '0;
            buf_vld_nx = 1'b0;
            state_nx   = start_sym ? S_PRE : S_DROP;
          end
        end
      end
      S_FLUSH: begin
        valid_nx   = 1'b1;
        last_nx    = 1'b1;
        data_nx    = buf_d;
        keep_nx    = buf_k;
        buf_vld_nx = 1'b0;
        state_nx   = (i_xgmii_vld && start_w) ? S_PRE : S_IDLE;
      end
      S_DROP: begin
        if (i_xgmii_vld) begin
          if (start_w)        state_nx = S_PRE;
          else if (drop_exit) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      buf_d   <= '0;
      buf_k   <= '0;
      buf_vld <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      buf_d   <= buf_d_nx;
      buf_k   <= buf_k_nx;
      buf_vld <= buf_vld_nx;
      o_data  <= data_nx;
      o_keep  <= keep_nx;
      o_valid <= valid_nx;
      o_last  <= last_nx;
      o_err   <= err_nx;
    end
  end
endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Scoreboard bench for xgmii_rx_deframer: frames are built from byte payloads,
// expected beats are derived by chopping the payload into 4-byte words.

module tb_xgmii_rx_deframer;
  localparam logic [31:0] START_W = 32'h555555FB;
  localparam logic [31:0] SFD_W   = 32'hD5555555;
  localparam logic [31:0] IDLE_W  = 32'h07070707;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        e;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] xd = '0;
  logic [3:0]  xc = '0;
  logic        xv = 1'b0;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  logic        o_valid, o_last, o_err;

  int n_tests = 0, n_fail = 0;
  int n_last_exp = 0, n_last_seen = 0;
  int cyc = 0, last_send_cyc = 0, last_beat_cyc = -1;
  bit gaps = 1'b0;
  beat_t exp_q[$];
  byte unsigned pl[$];

  xgmii_rx_deframer #(.W_DATA(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_xgmii_d   (xd),
    .i_xgmii_c   (xc),
    .i_xgmii_vld (xv),
    .o_data      (o_data),
    .o_keep      (o_keep),
    .o_valid     (o_valid),
    .o_last      (o_last),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic e);
    beat_t b;
    b.d = d; b.k = k; b.l = l; b.e = e;
    exp_q.push_back(b);
    if (l) n_last_exp++;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] c);
    while (gaps && $urandom_range(99) < 30) begin
      xv = 1'b0; xd = $urandom; xc = 4'($urandom);
      @(negedge clk);
    end
    xd = d; xc = c; xv = 1'b1; last_send_cyc = cyc;
    @(negedge clk);
    xv = 1'b0;
  endtask

  task automatic idles(input int n);
    repeat (n) send(IDLE_W, 4'hF);
  endtask

  task automatic rand_pl(input int len);
    pl.delete();
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  function automatic logic [31:0] pl_word(input int b);
    return {pl[4*b+3], pl[4*b+2], pl[4*b+1], pl[4*b]};
  endfunction

  task automatic frame_good();
    int len, nb;
    logic [31:0] w;
    logic [3:0]  k, c;
    len = pl.size();
    nb  = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      w = '0; k = '0;
      for (int j = 0; j < 4; j++)
        if (4*b + j < len) begin w[8*j +: 8] = pl[4*b+j]; k[j] = 1'b1; end
      push(w, k, b == nb - 1, 1'b0);
    end
    send(START_W, 4'b0001);
    send(SFD_W, 4'b0000);
    for (int b = 0; b < len / 4; b++) send(pl_word(b), 4'b0000);
    w = '0; c = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < len % 4) w[8*j +: 8] = pl[4*(len/4) + j];
      else begin
        c[j] = 1'b1;
        w[8*j +: 8] = (j == len % 4) ? 8'hFD : 8'h07;
      end
    end
    send(w, c);
  endtask

  // With restart set, the next frame's start word is the corrupting symbol.
  task automatic frame_err(input int nw, input int e, input bit restart);
    logic [31:0] w;
    logic [3:0]  c;
    rand_pl(4*nw + e);
    if (nw == 0) push(32'h0, 4'h0, 1'b1, 1'b1);
    for (int b = 0; b < nw; b++) push(pl_word(b), 4'hF, b == nw - 1, b == nw - 1);
    send(START_W, 4'b0001);
    send(SFD_W, 4'b0000);
    for (int b = 0; b < nw; b++) send(pl_word(b), 4'b0000);
    if (!restart) begin
      w = '0; c = '0;
      for (int j = 0; j < 4; j++) begin
        if (j < e) w[8*j +: 8] = pl[4*nw + j];
        else begin
          c[j] = 1'b1;
          w[8*j +: 8] = (j == e) ? 8'hFE : 8'h07;
        end
      end
      send(w, c);
      repeat ($urandom_range(2)) send($urandom, 4'h0);
      send(32'h070707FD, 4'hF);
    end
  endtask

  task automatic frame_badsfd();
    send(START_W, 4'b0001);
    send(32'h55555555, 4'b0000);
    repeat ($urandom_range(3)) send($urandom, 4'h0);
    send(32'h070707FD, 4'hF);
  endtask

  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && o_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_beat: got data=%h keep=%b last=%b err=%b, expected no beat",
                   o_data, o_keep, o_last, o_err);
        end else begin
          b = exp_q.pop_front();
          chk("beat{data,keep,last,err}", {o_data, o_keep, o_last, o_err}, b);
        end
        if (o_last) begin
          n_last_seen++;
          last_beat_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int t, kind;
    bit restart;
    restart = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_valid", 64'(o_valid), 64'(0));
    chk("reset_last",  64'(o_last),  64'(0));
    chk("reset_err",   64'(o_err),   64'(0));
    chk("reset_keep",  64'(o_keep),  64'(0));
    chk("reset_data",  64'(o_data),  64'(0));
    rst_n = 1'b1;
    idles(2);

    pl.delete();
    for (int i = 1; i <= 8; i++) pl.push_back(8'(i));
    frame_good();
    t = last_send_cyc;
    idles(3);
    chk("latency_term_lane0", 64'(last_beat_cyc), 64'(t + 1));

    pl.delete();
    for (int i = 1; i <= 6; i++) pl.push_back(8'(i));
    frame_good();
    t = last_send_cyc;
    idles(3);
    chk("latency_flush", 64'(last_beat_cyc), 64'(t + 2));

    frame_badsfd();
    rand_pl(12); frame_good(); idles(1);

    frame_err(1, 1, 1'b0); idles(1);
    rand_pl(9); frame_good(); idles(1);

    gaps = 1'b1;
    rand_pl(64); frame_good();
    gaps = 1'b0;
    idles(2);

    rand_pl(12);
    push(pl_word(0), 4'hF, 1'b0, 1'b0);
    push(pl_word(1), 4'hF, 1'b0, 1'b0);
    send(START_W, 4'b0001);
    send(SFD_W, 4'b0000);
    for (int i = 0; i < 3; i++) send(pl_word(i), 4'b0000);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(o_valid), 64'(0));
    chk("midreset_last",  64'(o_last),  64'(0));
    chk("midreset_data",  64'(o_data),  64'(0));
    chk("midreset_keep",  64'(o_keep),  64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_pl(10); frame_good(); idles(1);

    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(8);
      gaps = ($urandom_range(1) == 1);
      restart = 1'b0;
      if (kind <= 5) begin
        rand_pl($urandom_range(40));
        frame_good();
      end else if (kind <= 7) begin
        restart = ($urandom_range(3) == 0);
        frame_err($urandom_range(4), restart ? 0 : $urandom_range(3), restart);
      end else begin
        frame_badsfd();
      end
      if (!restart) idles($urandom_range(2));
    end
    gaps = 1'b0;
    rand_pl(7); frame_good();
    idles(4);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("last_beat_count", 64'(n_last_seen), 64'(n_last_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/xgmii_rx_deframer.md
# xgmii_rx_deframer

Receive-side frame extractor for the 10G Ethernet datapath. Consumes 32-bit XGMII-style lanes (data plus per-lane control flags) from the RX gearbox/decoder and strips the start, preamble, SFD, terminate and idle symbols. Emits frame payload as a stream of data, keep, valid, last and error beats toward the RX MAC. It is the counterpart of the TX framer that inserts these symbols from the shared symbol set (IDLE 0x07, START 0xFB, TERM 0xFD, ERR 0xFE, PREAM 0x55, SFD 0xD5).

## Interface
- W_DATA, 32, transfer width; only 32 is supported by this block (4 lanes, N_BYTES_PER_TRANS = 4)
- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous, active-low
- i_xgmii_d  in  32  lane data; lane 0 = bits [7:0] = first byte on the wire
- i_xgmii_c  in  4  per-lane control flag; bit k set means lane k is a control symbol
- i_xgmii_vld  in  1  input transfer qualifier; transfers with vld=0 are ignored (gearbox gaps)
- o_data  out  32  payload bytes, same lane order as input
- o_keep  out  4  valid-byte mask; contiguous from lane 0
- o_valid  out  1  output beat valid; there is no backpressure
- o_last  out  1  final beat of a frame
- o_err  out  1  frame is corrupt; only asserted together with o_last

## Operation
- States: IDLE, PRE (expecting second preamble word), DATA, FLUSH (emit final partial word), DROP (discard until end of corrupt frame).
- Holding register BUF: 32-bit word plus keep, with flag buf_vld. Payload words are delayed by one accepted transfer, because a terminate in lane 0 of word n+1 closes word n.
- IDLE: accepted word with c=0001, d=55_55_55_FB goes to PRE. Anything else stays in IDLE with no output.
- PRE: accepted word with c=0000, d=D5_55_55_55 goes to DATA with buf_vld=0. A start word goes back to PRE. Any other word goes to IDLE with no output.
- DATA, accepted word with c=0000: if buf_vld, emit BUF (keep=1111, last=0). Then BUF takes the input and buf_vld=1.
- DATA, FD in lane k with c bit k set and c bits 0..k-1 clear:
  - k=0: emit BUF with last=1 if buf_vld. If buf_vld=0 (zero-length payload), emit nothing. Go to IDLE.
  - k=1..3: emit BUF (last=0) if buf_vld. Load lanes 0..k-1 into BUF with keep = (1<<k)-1. Go to FLUSH.
- FLUSH: on the next cycle, unconditionally (independent of i_xgmii_vld), emit BUF with last=1 and the stored keep. Clear buf_vld and go to IDLE. An input accepted in this cycle is decoded as in IDLE.
- DATA, any control lane before a terminate (ERR, IDLE, START, or an unknown symbol):
  - Emit BUF with last=1, err=1. If buf_vld=0, emit a beat with keep=0000, last=1, err=1.
  - If the offending symbol is START in lane 0 with c=0001, go to PRE. Otherwise go to DROP.
- DROP: no output. Exit to IDLE on a word containing FD with its c bit set, or on a word with c=1111 and lane 0 = 07. A start word exits directly to PRE.
- On non-beat cycles, o_data and o_keep are don't-care but are driven to 0.

## Timing
- All outputs are registered. Reset values: o_valid=0, o_last=0, o_err=0, o_keep=0, o_data=0. State=IDLE, buf_vld=0.
- Latency: payload word n appears on o_* the cycle after the accepted transfer n+1 that resolves it. A partial final word appears one cycle after its FLUSH entry.
- Back-to-back frames with minimum IPG (terminate word followed immediately by a start word) are accepted with no lost frame.
- Gaps with i_xgmii_vld=0 inside a frame stall the pipeline and do not corrupt it. FLUSH is not stalled by gaps.
- rst_n asserted mid-frame: the frame is discarded and no last beat is emitted. After release, the block waits for the next start word.

## Test plan
- 8-byte payload 01..08 (words 04030201, 08070605), then FD in lane 0 -> two beats, keep=1111. The second beat has last=1 and appears 1 cycle after the FD word. err=0.
- 6-byte payload then FD in lane 2 (data 01,02,03,04 then 05,06,FD,07) -> beat 04030201 with last=0, next cycle beat 0000_0605 with keep=0011, last=1.
- Corrupt SFD (second word 55555555) -> no output, state back to IDLE. The following valid frame is received intact.
- FE control in lane 1 after 4 payload bytes -> beat with BUF, last=1, err=1. Subsequent words are dropped until FD. The next frame is clean.
- Random i_xgmii_vld gaps (30%) during a 64-byte frame -> output bytes and keep are identical to the gap-free run, and exactly one last beat.
- rst_n pulsed low mid-payload -> all outputs 0 immediately. No last beat. The next frame after release is decoded correctly.
